// File: rtl/adder_flit_injector.sv
// -----------------------------------------------------------------------------
// adder_flit_injector
//
// Purpose:
//   Sits directly upstream of the adder being characterised and feeds it a
//   repeatable operand stream. Each run has NUM_PKTS packets. A packet is
//   PAYLOAD data flits followed by GAP idle cycles. Flit k of a packet uses
//   entry (k mod 7) of a fixed 42-bit pattern table. The table is truncated
//   or zero-extended to 2N bits, and the flit is split into the two N-bit
//   adder operands. The payload/gap ratio sets the link utilisation for
//   energy and VCD runs.
//
// Optional feature:
//   ADDER_INJ_TOGGLE_CNT_EN adds the toggle_cnt_o port. It accumulates the
//   number of operand bit flips that each accepted flit causes at the adder
//   inputs, and it saturates at all-ones.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous reset, active low
//   start         in   begin a run (only honoured when idle or done)
//   ready_i       in   adder-side accept; transfer on valid_o & ready_i
//   valid_o       out  operands carry a flit
//   input1_o      out  flit[N-1:0]
//   input2_o      out  flit[2N-1:N]
//   sof_o / eof_o out  first / last flit of the packet
//   busy_o        out  sending or in an inter-packet gap
//   done_o        out  run complete, held until the next start
//   pkt_cnt_o     out  packets fully transferred in this run (wraps)
//   toggle_cnt_o  out  operand bit flips (only with ADDER_INJ_TOGGLE_CNT_EN)
// -----------------------------------------------------------------------------
module adder_flit_injector #(
    parameter int N        = 21,
    parameter int PAYLOAD  = 20,
    parameter int NUM_PKTS = 10,
    parameter int GAP      = 7,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [N-1:0]     input1_o,
    output logic [N-1:0]     input2_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      pkt_cnt_o
`ifdef ADDER_INJ_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] toggle_cnt_o
`endif
);

    localparam int FW  = 2 * N;
    localparam int FCW = $clog2(PAYLOAD + 1);
    localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_e;

    // Pattern table entry, resized to the flit width (truncate or zero-extend).
    function automatic logic [FW-1:0] patFlit(input logic [2:0] idx);
        logic [41:0] p;
        case (idx)
            3'd0:    p = 42'h3FFFFFC0000;
            3'd1:    p = 42'h00FFFFFFFFF;
            3'd2:    p = 42'h00000000FFF;
            3'd3:    p = 42'h3FFC0000000;
            3'd4:    p = 42'h3FFFFFFFFC0;
            3'd5:    p = 42'h00000FFFFFF;
            default: p = 42'h0;
        endcase
        return FW'(p);
    endfunction

    state_e          state_q;
    logic            valid_q;
    logic            sof_q;
    logic            eof_q;
    logic            busy_q;
    logic            done_q;
    logic [15:0]     pkt_cnt_q;
    logic [FW-1:0]   ops_q;
    logic [2:0]      idx_q;
    logic [FCW-1:0]  flit_cnt_q;
    logic [GCW-1:0]  gap_cnt_q;
    logic [31:0]     pkts_sent_q;

    logic            startRun;
    logic            accept;
    logic            lastFlit;
    logic            gapEnd;
    logic [2:0]      idxNext;
    logic [31:0]     pktsNext;
    logic            opsLoad_d;
    logic [FW-1:0]   opsNext_d;

    // Decide whether the operand register takes a new flit this cycle, and
    // which flit it takes. The FSM and the toggle counter share this decision,
    // so the counter always sees exactly the operand change the adder sees.
    // Every load other than a mid-packet advance starts a packet, so it uses P0.
    always_comb begin
        idxNext   = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
        lastFlit  = (flit_cnt_q == FCW'(PAYLOAD - 1));
        pktsNext  = pkts_sent_q + 32'd1;
        startRun  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
        accept    = (state_q == S_SEND) && ready_i;
        gapEnd    = (state_q == S_GAP) && (gap_cnt_q == GCW'(GAP - 1));
        opsLoad_d = 1'b0;
        opsNext_d = patFlit(3'd0);
        if (startRun && (NUM_PKTS != 0)) begin
            opsLoad_d = 1'b1;
        end else if (accept && !lastFlit) begin
            opsLoad_d = 1'b1;
            opsNext_d = patFlit(idxNext);
        end else if (accept && (GAP == 0) && (pktsNext < 32'(NUM_PKTS))) begin
            opsLoad_d = 1'b1;
        end else if (gapEnd && (pkts_sent_q < 32'(NUM_PKTS))) begin
            opsLoad_d = 1'b1;
        end
    end

    // Main sequencer. Every output is a register.
    // In SEND, valid_q stays high until the eof flit is accepted, so the flit
    // only advances on acceptance.
    // The gap counter ignores ready_i, and the operands hold the last flit
    // during the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pkt_cnt_q   <= '0;
            ops_q       <= '0;
            idx_q       <= '0;
            flit_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            pkts_sent_q <= '0;
        end else begin
            if (opsLoad_d) begin
                ops_q <= opsNext_d;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pkt_cnt_q   <= '0;
                        pkts_sent_q <= '0;
                        if (NUM_PKTS == 0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_SEND;
                            done_q     <= 1'b0;
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            sof_q      <= 1'b1;
                            eof_q      <= (PAYLOAD == 1);
                            flit_cnt_q <= '0;
                            idx_q      <= '0;
                        end
                    end
                end
                S_SEND: begin
                    if (ready_i) begin
                        if (!lastFlit) begin
                            flit_cnt_q <= flit_cnt_q + FCW'(1);
                            idx_q      <= idxNext;
                            sof_q      <= 1'b0;
                            eof_q      <= (flit_cnt_q == FCW'(PAYLOAD - 2));
                        end else begin
                            pkt_cnt_q   <= pkt_cnt_q + 16'd1;
                            pkts_sent_q <= pktsNext;
                            sof_q       <= 1'b0;
                            eof_q       <= 1'b0;
                            if (GAP != 0) begin
                                state_q   <= S_GAP;
                                valid_q   <= 1'b0;
                                gap_cnt_q <= '0;
                            end else if (pktsNext < 32'(NUM_PKTS)) begin
                                flit_cnt_q <= '0;
                                idx_q      <= '0;
                                sof_q      <= 1'b1;
                                eof_q      <= (PAYLOAD == 1);
                            end else begin
                                state_q <= S_DONE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (!gapEnd) begin
                        gap_cnt_q <= gap_cnt_q + GCW'(1);
                    end else if (pkts_sent_q < 32'(NUM_PKTS)) begin
                        state_q    <= S_SEND;
                        valid_q    <= 1'b1;
                        sof_q      <= 1'b1;
                        eof_q      <= (PAYLOAD == 1);
                        flit_cnt_q <= '0;
                        idx_q      <= '0;
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign valid_o   = valid_q;
    assign input1_o  = ops_q[N-1:0];
    assign input2_o  = ops_q[FW-1:N];
    assign sof_o     = sof_q;
    assign eof_o     = eof_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pkt_cnt_o = pkt_cnt_q;

`ifdef ADDER_INJ_TOGGLE_CNT_EN
    localparam int PCW = $clog2(FW + 1);
    localparam int SW  = CNT_W + 1;

    function automatic logic [PCW-1:0] popCount(input logic [FW-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < FW; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    logic [PCW-1:0]   pend_q;
    logic [CNT_W-1:0] toggle_q;
    logic [SW-1:0]    toggleSum;

    always_comb begin
        toggleSum = {1'b0, toggle_q} + SW'(pend_q);
    end

    // The flip count of a flit is computed when that flit is loaded onto the
    // operands. It is compared against the operands that were on the bus
    // before the load. The count is only credited once the flit is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= '0;
            pend_q   <= '0;
        end else begin
            if (startRun) begin
                toggle_q <= '0;
            end else if (accept) begin
                toggle_q <= toggleSum[CNT_W] ? '1 : toggleSum[CNT_W-1:0];
            end
            if (opsLoad_d) begin
                pend_q <= popCount(ops_q ^ opsNext_d);
            end
        end
    end

    assign toggle_cnt_o = toggle_q;
`endif

endmodule

// File: tb/tb_adder_flit_injector.sv
// -----------------------------------------------------------------------------
// tb_adder_flit_injector
//
// Drives three injectors:
//   - one with the default configuration;
//   - one with PAYLOAD=1, GAP=0 and a narrow flit (N=12);
//   - one with NUM_PKTS=0.
// For each run, the stimulus side pushes the expected flit sequence into a
// queue. Monitors pop the queue and compare on every accepted flit.
// -----------------------------------------------------------------------------
module tb_adder_flit_injector;

    localparam int N        = 21;
    localparam int PAYLOAD  = 20;
    localparam int NUM_PKTS = 10;
    localparam int GAP      = 7;
    localparam int CNT_W    = 32;
    localparam int FW       = 2 * N;
    localparam int NB       = 12;
    localparam int FWB      = 2 * NB;
    localparam int PAYB     = 1;
    localparam int PKTB     = 3;

    typedef struct {
        logic [63:0] data;
        logic        sof;
        logic        eof;
        longint      togBefore;
    } flit_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic startAux = 1'b0;
    logic ready = 1'b0;

    logic          valid, sof, eof, busy, done;
    logic [N-1:0]  in1, in2;
    logic [15:0]   pktCnt;
    logic          validB, sofB, eofB, busyB, doneB;
    logic [NB-1:0] in1B, in2B;
    logic [15:0]   pktCntB;
    logic          valid0, sof0, eof0, busy0, done0;
    logic [N-1:0]  in10, in20;
    logic [15:0]   pktCnt0;
`ifdef ADDER_INJ_TOGGLE_CNT_EN
    logic [CNT_W-1:0] toggleCnt, toggleCntB, toggleCnt0;
`endif

    adder_flit_injector #(.N(N), .PAYLOAD(PAYLOAD), .NUM_PKTS(NUM_PKTS), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready_i(ready), .valid_o(valid),
        .input1_o(in1), .input2_o(in2), .sof_o(sof), .eof_o(eof), .busy_o(busy),
        .done_o(done), .pkt_cnt_o(pktCnt)
`ifdef ADDER_INJ_TOGGLE_CNT_EN
        , .toggle_cnt_o(toggleCnt)
`endif
    );

    adder_flit_injector #(.N(NB), .PAYLOAD(PAYB), .NUM_PKTS(PKTB), .GAP(0), .CNT_W(CNT_W)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startAux), .ready_i(ready), .valid_o(validB),
        .input1_o(in1B), .input2_o(in2B), .sof_o(sofB), .eof_o(eofB), .busy_o(busyB),
        .done_o(doneB), .pkt_cnt_o(pktCntB)
`ifdef ADDER_INJ_TOGGLE_CNT_EN
        , .toggle_cnt_o(toggleCntB)
`endif
    );

    adder_flit_injector #(.N(N), .PAYLOAD(PAYLOAD), .NUM_PKTS(0), .GAP(GAP), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(startAux), .ready_i(ready), .valid_o(valid0),
        .input1_o(in10), .input2_o(in20), .sof_o(sof0), .eof_o(eof0), .busy_o(busy0),
        .done_o(done0), .pkt_cnt_o(pktCnt0)
`ifdef ADDER_INJ_TOGGLE_CNT_EN
        , .toggle_cnt_o(toggleCnt0)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          compared = 0;
    int          mismatched = 0;
    flit_t       expQ[$];
    flit_t       expQB[$];
    int          eofSeen = 0;
    logic [63:0] lastAcc = '0;
    logic [63:0] modelPrev = '0;
    longint      modelTog = 0;
    logic        holdArmed = 1'b0;
    logic [63:0] holdVal = '0;
    logic        valid0Seen = 1'b0;
    flit_t       monF;
    flit_t       monFB;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Reference pattern: table entry (k mod 7), cut down to fw bits.
    function automatic logic [63:0] patVal(input int k, input int fw);
        logic [63:0] p;
        case (k % 7)
            0:       p = 64'h3FFFFFC0000;
            1:       p = 64'h00FFFFFFFFF;
            2:       p = 64'h00000000FFF;
            3:       p = 64'h3FFC0000000;
            4:       p = 64'h3FFFFFFFFC0;
            5:       p = 64'h00000FFFFFF;
            default: p = 64'h0;
        endcase
        return p & ((64'd1 << fw) - 64'd1);
    endfunction

    // Expected flit stream of one full default run, with the running bit-flip
    // total that should be visible while each flit is presented.
    task automatic queueRun();
        flit_t f;
        eofSeen  = 0;
        modelTog = 0;
        for (int p = 0; p < NUM_PKTS; p++) begin
            for (int k = 0; k < PAYLOAD; k++) begin
                f.data      = patVal(k, FW);
                f.sof       = (k == 0);
                f.eof       = (k == PAYLOAD - 1);
                f.togBefore = modelTog;
                modelTog    = modelTog + longint'($countones(modelPrev ^ f.data));
                modelPrev   = f.data;
                expQ.push_back(f);
            end
        end
    endtask

    task automatic queueRunB();
        flit_t f;
        for (int p = 0; p < PKTB; p++) begin
            for (int k = 0; k < PAYB; k++) begin
                f.data      = patVal(k, FWB);
                f.sof       = (k == 0);
                f.eof       = (k == PAYB - 1);
                f.togBefore = 0;
                expQB.push_back(f);
            end
        end
    endtask

    task automatic applyStimulus(input logic s, input logic sAux);
        @(posedge clk);
        #1;
        start    = s;
        startAux = sAux;
        @(posedge clk);
        #1;
        start    = 1'b0;
        startAux = 1'b0;
    endtask

    // Monitor for the default injector. It compares every accepted flit and
    // checks operand stability under stall and during gaps.
    always @(negedge clk) begin
        if (!rst_n) begin
            holdArmed = 1'b0;
        end else begin
            if (holdArmed) begin
                checkOutput("stall valid held", {63'd0, valid}, 64'd1);
                checkOutput("stall operands stable", {22'd0, in2, in1}, holdVal);
            end
            holdArmed = valid && !ready;
            holdVal   = {22'd0, in2, in1};
            if (busy && !valid) begin
                checkOutput("gap operands hold", {22'd0, in2, in1}, lastAcc);
            end
            if (valid && ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected flit", {63'd0, valid}, 64'd0);
                end else begin
                    monF = expQ.pop_front();
                    checkOutput("flit operands", {22'd0, in2, in1}, monF.data);
                    checkOutput("flit sof", {63'd0, sof}, {63'd0, monF.sof});
                    checkOutput("flit eof", {63'd0, eof}, {63'd0, monF.eof});
                    checkOutput("pkt_cnt before accept", {48'd0, pktCnt}, 64'(eofSeen % 65536));
`ifdef ADDER_INJ_TOGGLE_CNT_EN
                    checkOutput("toggle_cnt before accept", 64'(toggleCnt), 64'(monF.togBefore));
`endif
                    lastAcc = monF.data;
                    if (monF.eof) eofSeen++;
                end
            end
        end
    end

    // Monitor for the PAYLOAD=1 / GAP=0 injector and the NUM_PKTS=0 one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid0) valid0Seen = 1'b1;
            if (validB && ready) begin
                if (expQB.size() == 0) begin
                    checkOutput("dutB unexpected flit", {63'd0, validB}, 64'd0);
                end else begin
                    monFB = expQB.pop_front();
                    checkOutput("dutB operands", {40'd0, in2B, in1B}, monFB.data);
                    checkOutput("dutB sof", {63'd0, sofB}, {63'd0, monFB.sof});
                    checkOutput("dutB eof", {63'd0, eofB}, {63'd0, monFB.eof});
                end
            end
        end
    end

    int c0;
    int bCycles;
    int bWait;

    initial begin
        // Reset state
        #22;
        checkOutput("reset valid", {63'd0, valid}, 64'd0);
        checkOutput("reset busy/done/sof/eof", {60'd0, busy, done, sof, eof}, 64'd0);
        checkOutput("reset operands", {22'd0, in2, in1}, 64'd0);
        checkOutput("reset pkt_cnt", {48'd0, pktCnt}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle no valid", {63'd0, valid}, 64'd0);

        // Run 1: ready always high, check latency and total run length
        queueRun();
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("first flit valid", {63'd0, valid}, 64'd1);
        checkOutput("first flit sof", {63'd0, sof}, 64'd1);
        c0 = cyc;
        for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
        checkOutput("run1 done", {63'd0, done}, 64'd1);
        checkOutput("run1 done latency", 64'(cyc - c0), 64'(NUM_PKTS * (PAYLOAD + GAP)));
        checkOutput("run1 pkt_cnt", {48'd0, pktCnt}, 64'(NUM_PKTS));
        checkOutput("run1 queue drained", 64'(expQ.size()), 64'd0);
`ifdef ADDER_INJ_TOGGLE_CNT_EN
        checkOutput("run1 toggle total", 64'(toggleCnt), 64'(modelTog));
`endif

        // Run 2: random backpressure, forced 3-cycle stall, start while busy
        queueRun();
        applyStimulus(1'b1, 1'b0);
        checkOutput("restart clears done", {63'd0, done}, 64'd0);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
            ready = (i >= 5 && i < 8) ? 1'b0 : ($urandom_range(0, 3) != 0);
            start = (i == 40);
        end
        start = 1'b0;
        ready = 1'b1;
        checkOutput("run2 done", {63'd0, done}, 64'd1);
        checkOutput("run2 pkt_cnt", {48'd0, pktCnt}, 64'(NUM_PKTS));
        checkOutput("run2 queue drained", 64'(expQ.size()), 64'd0);
        checkOutput("run2 busy low", {63'd0, busy}, 64'd0);
`ifdef ADDER_INJ_TOGGLE_CNT_EN
        checkOutput("run2 toggle total", 64'(toggleCnt), 64'(modelTog));
`endif

        // Run 3: asynchronous reset in the middle of the second packet
        queueRun();
        applyStimulus(1'b1, 1'b0);
        repeat (45) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset valid", {63'd0, valid}, 64'd0);
        checkOutput("async reset busy/done/sof/eof", {60'd0, busy, done, sof, eof}, 64'd0);
        checkOutput("async reset operands", {22'd0, in2, in1}, 64'd0);
        checkOutput("async reset pkt_cnt", {48'd0, pktCnt}, 64'd0);
        expQ.delete();
        modelPrev = '0;
        eofSeen   = 0;
        lastAcc   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("post reset no valid", {62'd0, valid, busy}, 64'd0);

        // Auxiliary configurations: PAYLOAD=1 back-to-back, NUM_PKTS=0
        queueRunB();
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("dut0 done one cycle after start", {63'd0, done0}, 64'd1);
        bCycles = 0;
        bWait   = 0;
        for (int i = 0; i < 20 && !doneB; i++) begin
            if (validB) bCycles++;
            bWait++;
            @(negedge clk);
        end
        checkOutput("dutB flit cycles", 64'(bCycles), 64'(PKTB * PAYB));
        checkOutput("dutB no bubbles", 64'(bWait), 64'(PKTB * PAYB));
        checkOutput("dutB done", {63'd0, doneB}, 64'd1);
        checkOutput("dutB pkt_cnt", {48'd0, pktCntB}, 64'(PKTB));
        checkOutput("dutB queue drained", 64'(expQB.size()), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("dut0 never valid", {63'd0, valid0Seen}, 64'd0);
        checkOutput("dut0 pkt_cnt", {48'd0, pktCnt0}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
